// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready issue front end for the combinational ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC
// into an ALU op and operand pair, then captures the ALU result for writeback.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [3:0]      w_op;
  logic [4:0]      w_rd;
  logic            w_illegal;
  logic            w_accept;
  logic            w_s2_load;

  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_s1_rd;
  logic            r_s1_illegal;
  logic            r_s1_valid;
  logic            r_out_valid;
  logic [4:0]      r_out_rd;
  logic [XLEN-1:0] r_out_result;
  logic            r_out_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = {in_instr[31:12], 12'b0};

  // Illegal encodings fall through with zero operands so the ALU result is zero.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_op      = 4'b0000;
    w_rd      = 5'd0;
    w_illegal = 1'b1;
    case (w_opcode)
      OpcOp: begin
        if (w_f7 == 7'b0000000 ||
            (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_a       = in_rs1;
          w_b       = in_rs2;
          w_op      = {in_instr[30], w_f3};
          w_rd      = in_instr[11:7];
          w_illegal = 1'b0;
        end
      end
      OpcOpImm: begin
        if ((w_f3 != 3'b001 && w_f3 != 3'b101) ||
            (w_f3 == 3'b001 && w_f7 == 7'b0000000) ||
            (w_f3 == 3'b101 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000))) begin
          w_a       = in_rs1;
          w_b       = w_imm_i;
          w_op      = {(w_f3 == 3'b101) ? in_instr[30] : 1'b0, w_f3};
          w_rd      = in_instr[11:7];
          w_illegal = 1'b0;
        end
      end
      OpcLui: begin
        w_b       = w_imm_u;
        w_rd      = in_instr[11:7];
        w_illegal = 1'b0;
      end
      OpcAuipc: begin
        w_a       = in_pc;
        w_b       = w_imm_u;
        w_rd      = in_instr[11:7];
        w_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= 4'b0000;
      r_s1_rd       <= 5'd0;
      r_s1_illegal  <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_rd      <= 5'd0;
      r_out_result  <= '0;
      r_out_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_a;
        r_alu_b      <= w_b;
        r_alu_op     <= w_op;
        r_s1_rd      <= w_rd;
        r_s1_illegal <= w_illegal;
        r_s1_valid   <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_valid   <= 1'b1;
        r_out_rd      <= r_s1_rd;
        r_out_result  <= alu_s;
        r_out_illegal <= r_s1_illegal;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign out_valid   = r_out_valid;
  assign out_rd      = r_out_rd;
  assign out_result  = r_out_result;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases plus randomized traffic scored against an
// instruction-level RV32I reference model.
module tb_alu_issue_stage;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_s;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_illegal;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  alu_issue_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_s      (alu_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_result (out_result),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The datapath ALU the stage drives.
  always_comb begin
    alu_s = 32'd0;
    case (alu_op)
      4'b0000: alu_s = alu_a + alu_b;
      4'b1000: alu_s = alu_a - alu_b;
      4'b0001: alu_s = alu_a << alu_b[4:0];
      4'b0010: alu_s = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0011: alu_s = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b0100: alu_s = alu_a ^ alu_b;
      4'b0101: alu_s = alu_a >> alu_b[4:0];
      4'b1101: alu_s = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_s = alu_a | alu_b;
      4'b0111: alu_s = alu_a & alu_b;
      default: alu_s = 32'd0;
    endcase
  end

  // Architectural result of one instruction, by mnemonic.
  function automatic exp_t ref_exec(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    logic [31:0] imm;
    logic [31:0] r;
    logic [4:0]  sh;
    bit          ok;
    e   = '{rd: 5'd0, res: 32'd0, ill: 1'b1};
    imm = {{20{instr[31]}}, instr[31:20]};
    r   = 32'd0;
    ok  = 1'b1;
    if (instr[6:0] == OP) begin
      sh = rs2[4:0];
      case ({instr[31:25], instr[14:12]})
        {7'h00, 3'd0}: r = rs1 + rs2;
        {7'h20, 3'd0}: r = rs1 - rs2;
        {7'h00, 3'd1}: r = rs1 << sh;
        {7'h00, 3'd2}: r = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: r = (rs1 < rs2) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: r = rs1 ^ rs2;
        {7'h00, 3'd5}: r = rs1 >> sh;
        {7'h20, 3'd5}: r = $unsigned($signed(rs1) >>> sh);
        {7'h00, 3'd6}: r = rs1 | rs2;
        {7'h00, 3'd7}: r = rs1 & rs2;
        default:       ok = 1'b0;
      endcase
    end else if (instr[6:0] == OPIMM) begin
      sh = instr[24:20];
      case (instr[14:12])
        3'd0: r = rs1 + imm;
        3'd2: r = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: r = (rs1 < imm) ? 32'd1 : 32'd0;
        3'd4: r = rs1 ^ imm;
        3'd6: r = rs1 | imm;
        3'd7: r = rs1 & imm;
        3'd1: begin
          ok = (instr[31:25] == 7'h00);
          r  = rs1 << sh;
        end
        default: begin
          if (instr[31:25] == 7'h00) r = rs1 >> sh;
          else if (instr[31:25] == 7'h20) r = $unsigned($signed(rs1) >>> sh);
          else ok = 1'b0;
        end
      endcase
    end else if (instr[6:0] == LUI) begin
      r = {instr[31:12], 12'b0};
    end else if (instr[6:0] == AUIPC) begin
      r = pc + {instr[31:12], 12'b0};
    end else begin
      ok = 1'b0;
    end
    if (ok) e = '{rd: instr[11:7], res: r, ill: 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, s2, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [31:0] t;
    w = $urandom();
    t = $urandom();
    case (t[2:0])
      3'd0, 3'd1: w[6:0] = OP;
      3'd2, 3'd3: w[6:0] = OPIMM;
      3'd4:       w[6:0] = LUI;
      3'd5:       w[6:0] = AUIPC;
      default:    ;
    endcase
    case (t[5:4])
      2'd0:    w[31:25] = 7'h00;
      2'd1:    w[31:25] = 7'h20;
      2'd2:    w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // One cycle: sample handshakes at negedge, score retirements, queue accepts.
  task automatic tick(output bit acc);
    exp_t got;
    exp_t want;
    @(negedge clk);
    acc = (in_valid && in_ready);
    if (out_valid === 1'b1 && out_ready) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL retire_unexpected: observed rd=%0d res=%h expected no result",
               out_rd, out_result);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {out_rd, out_result, out_illegal};
        tests++;
        assert (got === want) else begin
          fails++;
          $error("FAIL retire: observed rd=%0d res=%h ill=%b expected rd=%0d res=%h ill=%b",
                 got.rd, got.res, got.ill, want.rd, want.res, want.ill);
        end
      end
    end
    if (acc) exp_q.push_back(ref_exec(in_instr, in_pc, in_rs1, in_rs2));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_valid = 1'b1;
  endtask

  task automatic send_one(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [3:0] eop, input logic [31:0] eres, input logic eill);
    bit a;
    out_ready = 1'b1;
    drive(instr, pc, rs1, rs2);
    tick(a);
    chk({tag, "_acc"}, {31'd0, a}, 32'd1);
    in_valid = 1'b0;
    chk({tag, "_op"}, {28'd0, alu_op}, {28'd0, eop});
    chk({tag, "_lat0"}, {31'd0, out_valid}, 32'd0);
    tick(a);
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_result, eres);
    chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, eill});
    tick(a);
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(a);
    tick(a);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    bit a;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    in_rs1    = 32'd0;
    in_rs2    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);

    send_one("add", enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'd0, 32'd5, 32'd7,
             4'b0000, 32'd12, 1'b0);
    send_one("sub", enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, OP), 32'd0, 32'd3, 32'd5,
             4'b1000, 32'hFFFF_FFFE, 1'b0);
    send_one("srai", enc_i(12'h404, 5'd1, 3'd5, 5'd2, OPIMM), 32'd0, 32'h8000_0000, 32'd0,
             4'b1101, 32'hF800_0000, 1'b0);
    send_one("addi", enc_i(12'hFFF, 5'd1, 3'd0, 5'd7, OPIMM), 32'd0, 32'd1, 32'd0,
             4'b0000, 32'd0, 1'b0);
    send_one("lui", {20'h12345, 5'd5, LUI}, 32'd0, 32'd9, 32'd9,
             4'b0000, 32'h1234_5000, 1'b0);
    send_one("auipc", {20'h00001, 5'd6, AUIPC}, 32'h100, 32'd9, 32'd9,
             4'b0000, 32'h0000_1100, 1'b0);
    send_one("load", enc_i(12'h010, 5'd1, 3'd2, 5'd8, 7'b0000011), 32'd0, 32'd5, 32'd7,
             4'b0000, 32'd0, 1'b1);
    chk("load_rd", {27'd0, out_rd}, 32'd0);
    send_one("mul", enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd9, OP), 32'd0, 32'd5, 32'd7,
             4'b0000, 32'd0, 1'b1);
    send_one("slli_bad", enc_i(12'h403, 5'd1, 3'd1, 5'd10, OPIMM), 32'd0, 32'd5, 32'd0,
             4'b0000, 32'd0, 1'b1);

    // Backpressure: three adds producing 1, 2, 3 with writeback stalled.
    out_ready = 1'b0;
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11, OP), 32'd0, 32'd0, 32'd1);
    tick(a);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, OP), 32'd0, 32'd0, 32'd2);
    tick(a);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd13, OP), 32'd0, 32'd0, 32'd3);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_result", out_result, 32'd1);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      tick(a);
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      tick(a);
      n++;
    end while (!a && n < 10);
    chk("bp_third_accepted", {31'd0, a}, 32'd1);
    drain();

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd14, OP), 32'd0, 32'd4, 32'd4);
    tick(a);
    drive(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd15, OP), 32'd0, 32'd9, 32'd4);
    tick(a);
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_op", {28'd0, alu_op}, 32'd8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_alu_op", {28'd0, alu_op}, 32'd0);
    out_ready = 1'b1;
    repeat (5) tick(a);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_instr  = rand_instr();
      in_pc     = $urandom();
      in_rs1    = $urandom();
      in_rs2    = $urandom();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick(a);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
